// File: rtl/thermal_line_engine.sv
// Thermal printer line engine: shifts one dot line into the head, latches it,
// fires the strobe groups in turn, then steps the paper motor.
module thermal_line_engine #(
  parameter int DOTS           = 384,
  parameter int STB_GROUPS     = 6,
  parameter int CLK_DIV        = 4,
  parameter int STB_CYCLES     = 50000,
  parameter int STEPS_PER_LINE = 2,
  parameter int STEP_CYCLES    = 100000
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  half_step_i,
  input  logic                  dir_i,
  output logic                  DO,
  output logic                  CLKimpr,
  output logic                  LAT,
  output logic [STB_GROUPS-1:0] STB,
  output logic                  INA,
  output logic                  INA2,
  output logic                  INB,
  output logic                  INB2,
  output logic                  busy_o,
  output logic                  line_done_o
);

  localparam int BYTES   = DOTS / 8;
  localparam int M1      = (CLK_DIV > STB_CYCLES) ? CLK_DIV : STB_CYCLES;
  localparam int CNT_MAX = (M1 > STEP_CYCLES) ? M1 : STEP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BCW     = $clog2(BYTES + 1);
  localparam int GW      = $clog2(STB_GROUPS + 1);
  localparam int SW      = $clog2(STEPS_PER_LINE + 1);

  localparam logic [CW-1:0]  DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  STB_GAP    = CW'(STB_CYCLES);
  localparam logic [CW-1:0]  STEP_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [BCW-1:0] BYTE_LAST  = BCW'(BYTES - 1);
  localparam logic [GW-1:0]  GRP_LAST   = GW'(STB_GROUPS - 1);
  localparam logic [SW-1:0]  STEPN_LAST = SW'(STEPS_PER_LINE - 1);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LATCH, S_BURN, S_FEED, S_DONE} state_t;

  state_t         r_state, w_state_next;
  logic [7:0]     r_shreg, w_shreg_next;
  logic [3:0]     r_bit_cnt, w_bit_cnt_next;
  logic [BCW-1:0] r_byte_cnt, w_byte_cnt_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic           r_clk_hi, w_clk_hi_next;
  logic           r_shifting, w_shifting_next;
  logic [GW-1:0]  r_grp, w_grp_next;
  logic [SW-1:0]  r_step, w_step_next;
  logic [2:0]     r_phase, w_phase_next;
  logic           r_half, w_half_next;
  logic           r_dir, w_dir_next;

  logic       w_ready;
  logic       w_accept;
  logic [2:0] w_phase_inc;
  logic [2:0] w_phase_adv;
  logic [3:0] w_coil;

  // Ready is forced low while reset is held, not just after the first edge.
  assign w_ready     = !reset && ((r_state == S_IDLE) || ((r_state == S_SHIFT) && !r_shifting));
  assign w_accept    = valid_i && w_ready;
  assign w_phase_inc = r_half ? 3'd1 : 3'd2;
  assign w_phase_adv = r_dir ? (r_phase + w_phase_inc) : (r_phase - w_phase_inc);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_cnt      <= '0;
      r_clk_hi   <= 1'b0;
      r_shifting <= 1'b0;
      r_grp      <= '0;
      r_step     <= '0;
      r_phase    <= 3'd1;
      r_half     <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shreg    <= w_shreg_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_cnt      <= w_cnt_next;
      r_clk_hi   <= w_clk_hi_next;
      r_shifting <= w_shifting_next;
      r_grp      <= w_grp_next;
      r_step     <= w_step_next;
      r_phase    <= w_phase_next;
      r_half     <= w_half_next;
      r_dir      <= w_dir_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shreg_next    = r_shreg;
    w_bit_cnt_next  = r_bit_cnt;
    w_byte_cnt_next = r_byte_cnt;
    w_cnt_next      = r_cnt;
    w_clk_hi_next   = r_clk_hi;
    w_shifting_next = r_shifting;
    w_grp_next      = r_grp;
    w_step_next     = r_step;
    w_phase_next    = r_phase;
    w_half_next     = r_half;
    w_dir_next      = r_dir;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_next    = data_i;
          w_bit_cnt_next  = 4'd8;
          w_byte_cnt_next = '0;
          w_cnt_next      = '0;
          w_clk_hi_next   = 1'b0;
          w_shifting_next = 1'b1;
          w_half_next     = half_step_i;
          w_dir_next      = dir_i;
          w_state_next    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_shifting) begin
          if (r_cnt == DIV_LAST) begin
            w_cnt_next = '0;
            if (!r_clk_hi) begin
              w_clk_hi_next = 1'b1;
            end else begin
              w_clk_hi_next  = 1'b0;
              w_bit_cnt_next = r_bit_cnt - 4'd1;
              // The last bit is not shifted out so DO keeps it during the wait.
              if (r_bit_cnt == 4'd1) begin
                w_shifting_next = 1'b0;
                w_byte_cnt_next = r_byte_cnt + 1'b1;
                if (r_byte_cnt == BYTE_LAST)
                  w_state_next = S_LATCH;
              end else begin
                w_shreg_next = {r_shreg[6:0], 1'b0};
              end
            end
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end else if (w_accept) begin
          w_shreg_next    = data_i;
          w_bit_cnt_next  = 4'd8;
          w_cnt_next      = '0;
          w_shifting_next = 1'b1;
        end
      end
      S_LATCH: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt_next   = '0;
          w_grp_next   = '0;
          w_state_next = S_BURN;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_BURN: begin
        if (r_cnt == STB_GAP) begin
          w_cnt_next = '0;
          if (r_grp == GRP_LAST) begin
            w_step_next  = '0;
            w_phase_next = w_phase_adv;
            w_state_next = S_FEED;
          end else begin
            w_grp_next = r_grp + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_FEED: begin
        if (r_cnt == STEP_LAST) begin
          w_cnt_next = '0;
          if (r_step == STEPN_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_step_next  = r_step + 1'b1;
            w_phase_next = w_phase_adv;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Coil order is {INA, INA2, INB, INB2}.
  always_comb begin
    w_coil = 4'b0000;
    if (r_state == S_FEED) begin
      case (r_phase)
        3'd0: w_coil = 4'b1000;
        3'd1: w_coil = 4'b1010;
        3'd2: w_coil = 4'b0010;
        3'd3: w_coil = 4'b0110;
        3'd4: w_coil = 4'b0100;
        3'd5: w_coil = 4'b0101;
        3'd6: w_coil = 4'b0001;
        3'd7: w_coil = 4'b1001;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < STB_GROUPS; gi++) begin : g_stb
      assign STB[gi] = (r_state == S_BURN) && (r_grp == GW'(gi)) && (r_cnt != STB_GAP);
    end
  endgenerate

  assign {INA, INA2, INB, INB2} = w_coil;
  assign ready_o     = w_ready;
  assign DO          = r_shreg[7];
  assign CLKimpr     = r_clk_hi;
  assign LAT         = (r_state != S_LATCH);
  assign busy_o      = (r_state != S_IDLE);
  assign line_done_o = (r_state == S_DONE);

endmodule

// File: tb/tb_thermal_line_engine.sv
// Directed bench for thermal_line_engine: records a per-cycle trace of each
// line and compares it against hand-computed shift/latch/strobe/feed timing.
module tb_thermal_line_engine;

  localparam int CD        = 2;
  localparam int SC        = 10;
  localparam int STC       = 5;
  localparam int SHIFT_LEN = 16 * CD;
  localparam int BURN_LEN  = 2 * (SC + 1);
  localparam int FEED_LEN  = 2 * STC;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       half_step_i = 1'b0;
  logic       dir_i = 1'b0;
  logic       ready_o, DO, CLKimpr, LAT, INA, INA2, INB, INB2, busy_o, line_done_o;
  logic [1:0] STB;

  always #5 CLK = ~CLK;

  thermal_line_engine #(
    .DOTS(16), .STB_GROUPS(2), .CLK_DIV(CD), .STB_CYCLES(SC),
    .STEPS_PER_LINE(2), .STEP_CYCLES(STC)
  ) dut (
    .CLK(CLK), .reset(reset), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .half_step_i(half_step_i), .dir_i(dir_i), .DO(DO), .CLKimpr(CLKimpr), .LAT(LAT),
    .STB(STB), .INA(INA), .INA2(INA2), .INB(INB), .INB2(INB2),
    .busy_o(busy_o), .line_done_o(line_done_o)
  );

  typedef struct packed {
    logic       do_b;
    logic       clk;
    logic       lat;
    logic [1:0] stb;
    logic [3:0] coil;
    logic       done;
    logic       ready;
    logic       busy;
    logic       acc;
  } rec_t;

  rec_t trace[$];
  logic rec_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [31:0] obs_bits;
  logic [43:0] obs_stb;
  logic [3:0]  obs_coil0, obs_coil1, obs_coil_end;
  int obs_nbits, obs_nacc, obs_first_acc, obs_last_acc;
  int obs_lat_first, obs_lat_cnt, obs_done_idx, obs_ndone;

  always @(negedge CLK) begin
    if (rec_en) begin
      rec_t r;
      r = {DO, CLKimpr, LAT, STB, INA, INA2, INB, INB2, line_done_o, ready_o, busy_o,
           valid_i && ready_o};
      trace.push_back(r);
    end
  end

  function automatic rec_t rd(input int i);
    rec_t r;
    r = '1;
    if (i >= 0 && i < trace.size()) r = trace[i];
    return r;
  endfunction

  task automatic analyze();
    logic prev_clk;
    int b0;
    int f0;
    prev_clk = 1'b0;
    obs_bits = '0; obs_nbits = 0; obs_nacc = 0; obs_first_acc = -1; obs_last_acc = -1;
    obs_lat_first = -1; obs_lat_cnt = 0; obs_done_idx = -1; obs_ndone = 0;
    foreach (trace[i]) begin
      if (trace[i].clk && !prev_clk) begin
        obs_bits = {obs_bits[30:0], trace[i].do_b};
        obs_nbits++;
      end
      prev_clk = trace[i].clk;
      if (trace[i].acc) begin
        if (obs_first_acc < 0) obs_first_acc = i;
        obs_last_acc = i;
        obs_nacc++;
      end
      if (!trace[i].lat) begin
        if (obs_lat_first < 0) obs_lat_first = i;
        obs_lat_cnt++;
      end
      if (trace[i].done) begin
        if (obs_done_idx < 0) obs_done_idx = i;
        obs_ndone++;
      end
    end
    b0 = obs_lat_first + obs_lat_cnt;
    obs_stb = '0;
    for (int k = 0; k < BURN_LEN; k++) obs_stb = {obs_stb[41:0], rd(b0 + k).stb};
    f0 = b0 + BURN_LEN;
    obs_coil0    = rd(f0).coil;
    obs_coil1    = rd(f0 + STC).coil;
    obs_coil_end = rd(f0 + FEED_LEN).coil;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_line();
    trace.delete();
    rec_en = 1'b1;
  endtask

  // Leaves valid_i high after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    data_i  = b;
    valid_i = 1'b1;
    while (!ready_o && n < 300) begin
      step();
      n++;
    end
    if (!ready_o) begin
      n_cmp++; n_fail++;
      $display("FAIL send_byte_timeout: ready_o got 0 required 1 for byte %h", b);
    end
    step();
  endtask

  task automatic finish_line();
    int n;
    n = 0;
    valid_i = 1'b0;
    while (!line_done_o && n < 400) begin
      step();
      n++;
    end
    if (!line_done_o) begin
      n_cmp++; n_fail++;
      $display("FAIL line_done_timeout: line_done_o got 0 required 1");
    end
    repeat (3) step();
    rec_en = 1'b0;
    analyze();
  endtask

  task automatic test_reset();
    int n;
    valid_i = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({ready_o, LAT, STB, DO, CLKimpr, busy_o, line_done_o} !== 8'b0100_0000) begin
      n_fail++;
      $display("FAIL reset_held: {ready,LAT,STB,DO,CLKimpr,busy,done} got %b required 01000000",
               {ready_o, LAT, STB, DO, CLKimpr, busy_o, line_done_o});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({ready_o, busy_o, INA, INA2, INB, INB2} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_release: {ready,busy,coils} got %b required 100000",
               {ready_o, busy_o, INA, INA2, INB, INB2});
    end
    step();

    // Abort mid-shift.
    half_step_i = 1'b1; dir_i = 1'b1;
    send_byte(8'hFF);
    valid_i = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({busy_o, DO} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_shift: {busy,DO} got %b required 11", {busy_o, DO});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, DO, CLKimpr, ready_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_shift: {busy,DO,CLKimpr,ready} got %b required 0000",
               {busy_o, DO, CLKimpr, ready_o});
    end
    step(); step();
    reset = 1'b0;
    step();

    // Abort mid-burn.
    send_byte(8'h12);
    send_byte(8'h34);
    valid_i = 1'b0;
    n = 0;
    while (STB == 2'b00 && n < 200) begin
      step();
      n++;
    end
    n_cmp++;
    if (STB !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_reset_burn: STB got %b required 01", STB);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({STB, LAT, busy_o} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_mid_burn: {STB,LAT,busy} got %b required 0010", {STB, LAT, busy_o});
    end
    step(); step();
    reset = 1'b0;
    step();

    // Abort mid-feed: half-step forward from phase 1 gives phase 2 (B+).
    send_byte(8'h56);
    send_byte(8'h78);
    valid_i = 1'b0;
    n = 0;
    while ({INA, INA2, INB, INB2} == 4'b0000 && n < 200) begin
      step();
      n++;
    end
    n_cmp++;
    if ({INA, INA2, INB, INB2} !== 4'b0010) begin
      n_fail++;
      $display("FAIL pre_reset_feed: coils got %b required 0010", {INA, INA2, INB, INB2});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({INA, INA2, INB, INB2, busy_o, line_done_o} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_mid_feed: {coils,busy,done} got %b required 000000",
               {INA, INA2, INB, INB2, busy_o, line_done_o});
    end
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [43:0] exp_stb;
    half_step_i = 1'b0; dir_i = 1'b1;
    start_line();
    send_byte(8'hA5);
    send_byte(8'h3C);
    finish_line();
    n_cmp++;
    if (obs_bits !== 32'h0000A53C || obs_nbits != 16) begin
      n_fail++;
      $display("FAIL b2b_bits: got %h (%0d edges) required 0000a53c (16 edges)", obs_bits, obs_nbits);
    end
    n_cmp++;
    if (obs_last_acc - obs_first_acc != SHIFT_LEN + 1) begin
      n_fail++;
      $display("FAIL b2b_ready_gap: accept spacing got %0d required %0d",
               obs_last_acc - obs_first_acc, SHIFT_LEN + 1);
    end
    n_cmp++;
    if ({rd(obs_first_acc + 1).do_b, rd(obs_first_acc + CD).clk, rd(obs_first_acc + CD + 1).clk} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_first_bit: {DO@t+1,CLK@t+CD,CLK@t+1+CD} got %b required 101",
               {rd(obs_first_acc + 1).do_b, rd(obs_first_acc + CD).clk, rd(obs_first_acc + CD + 1).clk});
    end
    n_cmp++;
    if (obs_lat_first != obs_last_acc + 1 + SHIFT_LEN || obs_lat_cnt != CD) begin
      n_fail++;
      $display("FAIL b2b_latch: LAT low start %0d len %0d required start %0d len %0d",
               obs_lat_first, obs_lat_cnt, obs_last_acc + 1 + SHIFT_LEN, CD);
    end
    exp_stb = '0;
    for (int k = 0; k < BURN_LEN; k++) begin
      logic [1:0] v;
      v = (k < 10) ? 2'b01 : (k == 10) ? 2'b00 : (k < 21) ? 2'b10 : 2'b00;
      exp_stb = {exp_stb[41:0], v};
    end
    n_cmp++;
    if (obs_stb !== exp_stb) begin
      n_fail++;
      $display("FAIL b2b_strobes: got %h required %h", obs_stb, exp_stb);
    end
    n_cmp++;
    if ({obs_coil0, obs_coil1, obs_coil_end} !== 12'b0110_0101_0000) begin
      n_fail++;
      $display("FAIL b2b_full_fwd_coils: got %b required 011001010000",
               {obs_coil0, obs_coil1, obs_coil_end});
    end
    n_cmp++;
    if (obs_done_idx != obs_lat_first + CD + BURN_LEN + FEED_LEN || obs_ndone != 1) begin
      n_fail++;
      $display("FAIL b2b_done: pulse at %0d count %0d required at %0d count 1",
               obs_done_idx, obs_ndone, obs_lat_first + CD + BURN_LEN + FEED_LEN);
    end
  endtask

  task automatic test_gapped();
    int n;
    int bad;
    half_step_i = 1'b0; dir_i = 1'b1;
    start_line();
    send_byte(8'hA5);
    valid_i = 1'b0;
    n = 0;
    while (!ready_o && n < 100) begin
      step();
      n++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ready_o || CLKimpr) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL gap_idle: cycles with ready=0 or CLKimpr=1 got %0d required 0", bad);
    end
    send_byte(8'h3C);
    finish_line();
    n_cmp++;
    if (obs_bits !== 32'h0000A53C || obs_nbits != 16 || obs_nacc != 2) begin
      n_fail++;
      $display("FAIL gap_bits: got %h (%0d edges, %0d accepts) required 0000a53c (16, 2)",
               obs_bits, obs_nbits, obs_nacc);
    end
    // Continues from phase 5: 7 then wraps to 1.
    n_cmp++;
    if ({obs_coil0, obs_coil1, obs_coil_end} !== 12'b1001_1010_0000) begin
      n_fail++;
      $display("FAIL gap_full_fwd_wrap: got %b required 100110100000",
               {obs_coil0, obs_coil1, obs_coil_end});
    end
  endtask

  task automatic test_half_reverse();
    half_step_i = 1'b1; dir_i = 1'b0;
    start_line();
    send_byte(8'hFF);
    send_byte(8'h01);
    finish_line();
    n_cmp++;
    if (obs_bits !== 32'h0000FF01) begin
      n_fail++;
      $display("FAIL hrev_bits: got %h required 0000ff01", obs_bits);
    end
    n_cmp++;
    if ({obs_coil0, obs_coil1, obs_coil_end} !== 12'b1000_1001_0000) begin
      n_fail++;
      $display("FAIL hrev_wrap_coils: got %b required 100010010000",
               {obs_coil0, obs_coil1, obs_coil_end});
    end
  endtask

  task automatic test_handshake();
    int n;
    int bad;
    logic [7:0] junk;
    half_step_i = 1'b1; dir_i = 1'b1;
    start_line();
    send_byte(8'h5A);
    // Mode pins change after the first byte and must be ignored for this line.
    half_step_i = 1'b0; dir_i = 1'b0;
    junk = 8'h0F;
    n = 0;
    while (!ready_o && n < 100) begin
      data_i = junk;
      junk = junk + 8'h11;
      step();
      n++;
    end
    if (!ready_o) begin
      n_cmp++; n_fail++;
      $display("FAIL hs_ready_timeout: ready_o got 0 required 1");
    end
    data_i = 8'hC3;
    step();
    n = 0;
    while (!line_done_o && n < 300) begin
      data_i = junk;
      junk = junk + 8'h11;
      step();
      n++;
    end
    finish_line();
    n_cmp++;
    if (obs_bits !== 32'h00005AC3 || obs_nacc != 2) begin
      n_fail++;
      $display("FAIL hs_bytes: got %h with %0d accepts required 00005ac3 with 2", obs_bits, obs_nacc);
    end
    bad = 0;
    for (int i = obs_first_acc + 1; i <= obs_done_idx; i++) if (!rd(i).busy) bad++;
    n_cmp++;
    if (bad != 0 || rd(obs_done_idx + 1).busy !== 1'b0 || obs_done_idx < 0) begin
      n_fail++;
      $display("FAIL hs_busy: idle cycles inside line got %0d, busy after done got %b required 0 and 0",
               bad, rd(obs_done_idx + 1).busy);
    end
    // Half-step forward from 7 wraps to 0 then 1.
    n_cmp++;
    if ({obs_coil0, obs_coil1, obs_coil_end} !== 12'b1000_1010_0000) begin
      n_fail++;
      $display("FAIL hs_mode_sampled: got %b required 100010100000",
               {obs_coil0, obs_coil1, obs_coil_end});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_half_reverse();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/thermal_line_engine.md
# thermal_line_engine

Parametrised thermal-printer line engine for the UART-to-printer datapath. It accepts a byte stream from the UART receiver and shifts one full dot line into the print head (DO/CLKimpr). It then latches the line (LAT) and fires the heater strobes group by group, with a configurable burn time and group count. Finally it advances the paper a configurable number of motor steps in full- or half-step mode. It replaces the separate data-sender, latch/strobe and motor blocks with one sequenced controller that has a ready/valid byte input and a per-line completion pulse.

## Interface
Parameters:
- DOTS, 384: dots per line; multiple of 8, ≥8.
- STB_GROUPS, 6: number of independent strobe lines, ≥1.
- CLK_DIV, 4: CLK cycles per CLKimpr half-period and LAT low width, ≥1.
- STB_CYCLES, 50000: CLK cycles each strobe stays high, ≥1.
- STEPS_PER_LINE, 2: motor steps per line, ≥1.
- STEP_CYCLES, 100000: CLK cycles each motor step is held, ≥1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_i  in  8  dot byte; bit 7 is the first dot shifted.
- valid_i  in  1  data_i valid.
- ready_o  out  1  engine can accept a byte. A transfer occurs when valid_i && ready_o at a rising edge.
- half_step_i  in  1  step mode, sampled when the first byte of a line is accepted: 1 = half-step, 0 = full-step.
- dir_i  in  1  feed direction, sampled with half_step_i: 1 = phase +, 0 = phase −.
- DO  out  1  head serial data.
- CLKimpr  out  1  head shift clock; head samples on the rising edge.
- LAT  out  1  head latch, active low.
- STB  out  STB_GROUPS  strobes, active high; at most one high at a time.
- INA, INA2, INB, INB2  out  1  motor coil drive.
- busy_o  out  1  high whenever the state is not IDLE.
- line_done_o  out  1  one-cycle pulse at the end of each line.

## Operation
States: IDLE, SHIFT, LATCH, BURN, FEED, DONE.

- **IDLE**
  - ready_o=1.
  - On a byte transfer: load the shift register, set bit_cnt=8, byte_cnt=0, capture mode/dir, go to SHIFT.
- **SHIFT**
  - Each bit drives DO=shreg[7]. CLKimpr is low for CLK_DIV cycles, then high for CLK_DIV cycles. Then shift left and decrement bit_cnt.
  - After 8 bits, byte_cnt increments.
  - If byte_cnt==DOTS/8, go to LATCH.
  - Otherwise stay in SHIFT with ready_o=1 and CLKimpr=0; DO holds its last value. Wait any number of cycles for the next byte, which loads and restarts the bit sequence.
  - ready_o=0 while bits are shifting.
- **LATCH**
  - LAT=0 for CLK_DIV cycles, then go to BURN with LAT=1.
- **BURN**
  - For g = 0..STB_GROUPS-1: STB[g]=1 for STB_CYCLES cycles, then all STB=0 for 1 cycle.
  - After the gap following the last group, go to FEED.
- **FEED**
  - STEPS_PER_LINE steps.
  - At the start of each step, the 3-bit phase moves by ±1 (half-step) or ±2 (full-step), modulo 8. Coils drive that phase for STEP_CYCLES cycles.
  - Phase table, with coil A = INA/INA2 and coil B = INB/INB2 (A+ means INA=1, INA2=0; A− means INA=0, INA2=1; off means 0,0):
    - 0: A+
    - 1: A+B+
    - 2: B+
    - 3: A−B+
    - 4: A−
    - 5: A−B−
    - 6: B−
    - 7: A+B−
  - Full-step from an even phase gives single-coil (wave) drive; this is accepted behaviour.
  - Coils are off in every state other than FEED. The phase register persists across lines.
- **DONE**
  - line_done_o=1 for one cycle, then return to IDLE.

Boundary conditions:
- valid_i is ignored while ready_o=0.
- The data_i/valid_i stream is never dropped or duplicated.
- The phase wraps 7→0 and 0→7.

## Timing
- Reset values: ready_o=0 during reset and 1 in the first cycle after release (IDLE). DO=0, CLKimpr=0, LAT=1, STB=0, all coils 0, busy_o=0, line_done_o=0, phase=1, all counters 0.
- Reset asserted mid-line aborts immediately to these values. A partial line is discarded and STB/coils drop in the same cycle as reset assertion.
- Byte accepted at edge t:
  - DO is valid from cycle t+1.
  - CLKimpr rises at cycle t+1+CLK_DIV.
  - Each bit takes 2·CLK_DIV cycles.
  - ready_o reasserts at cycle t+1+16·CLK_DIV.
- Last byte accepted at t:
  - LAT is low for cycles t+1+16·CLK_DIV … t+16·CLK_DIV+CLK_DIV.
  - STB[0] rises in the following cycle.
- BURN lasts STB_GROUPS·(STB_CYCLES+1) cycles.
- FEED lasts STEPS_PER_LINE·STEP_CYCLES cycles.
- line_done_o is in the cycle after FEED ends.
- Counters are sized with $clog2 of their maximum value. No width truncation is allowed at the parameter maxima.

## Test plan
Parameters for all scenarios: DOTS=16, STB_GROUPS=2, CLK_DIV=2, STB_CYCLES=10, STEPS_PER_LINE=2, STEP_CYCLES=5.

1. **Reset values.** Assert reset mid-stream -> all outputs take their reset values in the same cycle. After release: ready_o=1, phase=1.
2. **Back-to-back line.** Send bytes 0xA5 then 0x3C back-to-back (valid held high) -> 16 CLKimpr rising edges carry DO bits 1010010100111100. Then LAT is low for exactly 2 cycles. Then STB=01 for 10 cycles, 00 for 1, 10 for 10, 00 for 1. Then 2 steps of 5 cycles, then one line_done_o pulse.
3. **Full-step forward.** half_step_i=0, dir_i=1 from phase 1 -> coil phases 3 (A−B+) then 5 (A−B−). Coils are 0 after FEED; the next line starts from phase 5.
4. **Half-step reverse with wrap.** half_step_i=1, dir_i=0 starting at phase 1 -> phases 0 (A+) then 7 (A+B−).
5. **Gapped input.** Hold valid_i low for 20 cycles between byte 1 and byte 2 -> CLKimpr stays 0 and ready_o=1 throughout the gap. Shifted data is identical to scenario 2.
6. **Handshake integrity.** Hold valid_i high with changing data while ready_o=0 -> only bytes present at ready cycles are shifted. Exactly 2 bytes are consumed per line and busy_o=1 from the first accept to line_done_o.
